multi_cycle_seq: RTL and testbench

Multi-cycle sequencer for the RV32 core. It steps one instruction at a time through FETCH, DECODE, EXEC, MEM and WB. It drives the write enables for the shared single-port memory, the instruction register, the PC, the ALU-result register, the memory-data register and the register file. The combinational instruction decoder still supplies the datapath selects; this block gates the enables in time and owns the memory handshake.

---
 rtl/multi_cycle_seq_if.sv | 21 ++
 rtl/multi_cycle_seq.sv | 124 ++++++++++++
 tb/tb_multi_cycle_seq.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_cycle_seq_if.sv
// Memory handshake between the multi-cycle sequencer and the shared single-port memory.
interface multi_cycle_seq_if;
    logic mem_req;
    logic mem_we;
    logic mem_is_ifetch;
    logic mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_is_ifetch,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_is_ifetch,
        output mem_ack
    );
endinterface

// File: rtl/multi_cycle_seq.sv
// RV32 multi-cycle sequencer: steps FETCH/DECODE/EXEC/MEM/WB, gates datapath
// write enables in time and owns the memory handshake.
module multi_cycle_seq #(
    parameter int unsigned CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    multi_cycle_seq_if.master    mem,
    output logic                 ir_we,
    output logic                 ex_we,
    output logic                 mdr_we,
    output logic                 rf_wr,
    output logic                 pc_we,
    output logic [2:0]           state,
    output logic                 halted,
    output logic [CNT_W-1:0]     instr_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    state_t state_q;
    state_t state_d;
    logic   legal_op;
    logic   req;
    logic   we;
    logic   ifetch;

    always_comb begin
        legal_op = 1'b0;
        case (opcode)
            OP_R, OP_I, OP_LOAD, OP_S, OP_B, OP_LUI, OP_JAL, OP_JALR: legal_op = 1'b1;
            default: legal_op = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        we      = 1'b0;
        ifetch  = 1'b0;
        ir_we   = 1'b0;
        ex_we   = 1'b0;
        mdr_we  = 1'b0;
        rf_wr   = 1'b0;
        pc_we   = 1'b0;
        halted  = 1'b0;
        case (state_q)
            S_FETCH: begin
                req    = 1'b1;
                ifetch = 1'b1;
                if (mem.mem_ack) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = legal_op ? S_EXEC : S_HALT;
            S_EXEC: begin
                ex_we = 1'b1;
                if (opcode == OP_LOAD || opcode == OP_S) begin
                    state_d = S_MEM;
                end else if (opcode == OP_B) begin
                    pc_we   = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                req = 1'b1;
                we  = (opcode == OP_S);
                if (mem.mem_ack) begin
                    if (opcode == OP_S) begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        mdr_we  = 1'b1;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_wr   = 1'b1;
                pc_we   = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            // Unused encodings fall back to a fresh fetch.
            default: state_d = S_FETCH;
        endcase
    end

    assign mem.mem_req       = req;
    assign mem.mem_we        = we;
    assign mem.mem_is_ifetch = ifetch;
    assign state             = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        instr_cnt <= '0;
        else if (pc_we) instr_cnt <= instr_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_multi_cycle_seq.sv
// Directed bench for multi_cycle_seq; a second CNT_W=4 instance covers counter wrap.
`timescale 1ns/100ps
module tb_multi_cycle_seq;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_BAD  = 7'h7F;

    // {state, req, we, ifetch, ir_we, ex_we, mdr_we, rf_wr, pc_we, halted}
    localparam logic [11:0] F_W  = {3'd0, 9'b1_0_1_0_0_0_0_0_0};
    localparam logic [11:0] F_A  = {3'd0, 9'b1_0_1_1_0_0_0_0_0};
    localparam logic [11:0] D    = {3'd1, 9'b0_0_0_0_0_0_0_0_0};
    localparam logic [11:0] E_X  = {3'd2, 9'b0_0_0_0_1_0_0_0_0};
    localparam logic [11:0] E_B  = {3'd2, 9'b0_0_0_0_1_0_0_1_0};
    localparam logic [11:0] ML_W = {3'd3, 9'b1_0_0_0_0_0_0_0_0};
    localparam logic [11:0] ML_A = {3'd3, 9'b1_0_0_0_0_1_0_0_0};
    localparam logic [11:0] MS_W = {3'd3, 9'b1_1_0_0_0_0_0_0_0};
    localparam logic [11:0] MS_A = {3'd3, 9'b1_1_0_0_0_0_0_1_0};
    localparam logic [11:0] W    = {3'd4, 9'b0_0_0_0_0_0_1_1_0};
    localparam logic [11:0] H    = {3'd5, 9'b0_0_0_0_0_0_0_0_1};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ack = 1'b0;
    logic [6:0]  opcode = OP_R;
    int          checks = 0;
    int          errors = 0;

    logic        ir_we, ex_we, mdr_we, rf_wr, pc_we, halted;
    logic [2:0]  state;
    logic [31:0] instr_cnt;
    logic        ir_we4, ex_we4, mdr_we4, rf_wr4, pc_we4, halted4;
    logic [2:0]  state4;
    logic [3:0]  instr_cnt4;

    multi_cycle_seq_if bus ();
    multi_cycle_seq_if bus4 ();
    assign bus.mem_ack  = ack;
    assign bus4.mem_ack = ack;

    always #10 clk = ~clk;

    multi_cycle_seq dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem(bus),
        .ir_we(ir_we), .ex_we(ex_we), .mdr_we(mdr_we), .rf_wr(rf_wr), .pc_we(pc_we),
        .state(state), .halted(halted), .instr_cnt(instr_cnt)
    );

    multi_cycle_seq #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .opcode(opcode), .mem(bus4),
        .ir_we(ir_we4), .ex_we(ex_we4), .mdr_we(mdr_we4), .rf_wr(rf_wr4), .pc_we(pc_we4),
        .state(state4), .halted(halted4), .instr_cnt(instr_cnt4)
    );

    function automatic logic [11:0] obs();
        return {state, bus.mem_req, bus.mem_we, bus.mem_is_ifetch,
                ir_we, ex_we, mdr_we, rf_wr, pc_we, halted};
    endfunction

    // Leaves time at posedge+1 with reset released and the DUT in FETCH.
    task automatic do_reset();
        ack = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        ack = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #2;
        checks++;
        if (obs() !== F_W) begin
            errors++;
            $display("FAIL reset_outputs got %h want %h", obs(), F_W);
        end
        checks++;
        if (instr_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d want 0", instr_cnt);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_rtype();
        logic [11:0] e [5];
        e = '{F_A, D, E_X, W, F_A};
        do_reset();
        opcode = OP_R;
        for (int i = 0; i < 5; i++) begin
            ack = 1'b1;
            #1;
            checks++;
            if (obs() !== e[i]) begin
                errors++;
                $display("FAIL rtype_cyc%0d got %h want %h", i, obs(), e[i]);
            end
            if (i < 4) begin
                @(posedge clk);
                #1;
            end
        end
        checks++;
        if (instr_cnt !== 32'd1) begin
            errors++;
            $display("FAIL rtype_cnt got %0d want 1", instr_cnt);
        end
    endtask

    task automatic test_load_wait();
        logic [11:0] e [11];
        logic        a [11];
        e = '{F_W, F_W, F_W, F_A, D, E_X, ML_W, ML_W, ML_W, ML_A, W};
        a = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        opcode = OP_LOAD;
        for (int i = 0; i < 11; i++) begin
            ack = a[i];
            #1;
            checks++;
            if (obs() !== e[i]) begin
                errors++;
                $display("FAIL load_cyc%0d got %h want %h", i, obs(), e[i]);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (instr_cnt !== 32'd1) begin
            errors++;
            $display("FAIL load_cnt got %0d want 1", instr_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] e [7];
        logic [6:0]  o [7];
        e = '{F_A, D, E_X, MS_A, F_A, D, E_B};
        o = '{OP_S, OP_S, OP_S, OP_S, OP_B, OP_B, OP_B};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            ack = 1'b1;
            opcode = o[i];
            #1;
            checks++;
            if (obs() !== e[i]) begin
                errors++;
                $display("FAIL sb_cyc%0d got %h want %h", i, obs(), e[i]);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (instr_cnt !== 32'd2) begin
            errors++;
            $display("FAIL sb_cnt got %0d want 2", instr_cnt);
        end
    endtask

    // Continues from test_back_to_back without reset so the count must stay at 2.
    task automatic test_halt();
        opcode = OP_BAD;
        for (int i = 0; i < 22; i++) begin
            ack = (i < 2) ? 1'b1 : i[0];
            #1;
            checks++;
            if (obs() !== ((i == 0) ? F_A : (i == 1) ? D : H)) begin
                errors++;
                $display("FAIL halt_cyc%0d got %h", i, obs());
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (instr_cnt !== 32'd2) begin
            errors++;
            $display("FAIL halt_cnt got %0d want 2", instr_cnt);
        end
    endtask

    task automatic test_reset_mid_store();
        do_reset();
        ack = 1'b1;
        opcode = OP_R;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        opcode = OP_S;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        ack = 1'b0;
        #1;
        checks++;
        if (obs() !== MS_W) begin
            errors++;
            $display("FAIL mid_store_wait got %h want %h", obs(), MS_W);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (obs() !== F_W) begin
            errors++;
            $display("FAIL mid_store_rst got %h want %h", obs(), F_W);
        end
        checks++;
        if (instr_cnt !== 32'd0) begin
            errors++;
            $display("FAIL mid_store_cnt got %0d want 0", instr_cnt);
        end
        #1 rst = 1'b0;
        ack = 1'b1;
        opcode = OP_R;
        #1;
        checks++;
        if (obs() !== F_A) begin
            errors++;
            $display("FAIL resume_fetch got %h want %h", obs(), F_A);
        end
        @(posedge clk);
        #2;
        checks++;
        if (obs() !== D) begin
            errors++;
            $display("FAIL resume_decode got %h want %h", obs(), D);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        ack = 1'b1;
        opcode = OP_R;
        for (int k = 1; k <= 17; k++) begin
            repeat (4) begin
                @(posedge clk);
                #1;
            end
            checks++;
            if (instr_cnt4 !== 4'(k % 16)) begin
                errors++;
                $display("FAIL wrap4_k%0d got %0d want %0d", k, instr_cnt4, k % 16);
            end
            checks++;
            if (instr_cnt !== 32'(k)) begin
                errors++;
                $display("FAIL wrap32_k%0d got %0d want %0d", k, instr_cnt, k);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_wait();
        test_back_to_back();
        test_halt();
        test_reset_mid_store();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
